riscv_crypto_aes32_pipe: RTL and testbench
==========================================

Name: riscv_crypto_aes32_pipe

Overview:
- Two-stage pipelined RISC-V Zkne/Zknd AES32 datapath that executes aes32esi, aes32esmi, aes32dsi and aes32dsmi.
- Consumes rs1/rs2/bs from the execute stage.
- Runs the selected byte through the shared S-box layers (top, middle, bottom):
  - forward S-box for encrypt ops, inverse S-box for decrypt ops.
  - The bottom (outer) layer sits after the pipeline register.
- Applies the partial MixColumn or InvMixColumn, rotates, and XORs the result into rs1.
- Valid/ready handshake on both sides gives full backpressure.

Parameters:
- MID_REG, 1, 1 = register the 18-bit middle-layer output before the bottom layer (latency 2); 0 = stage 1 is a pass-through and latency is 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request this cycle.
- op_i  input  2  00 = esi, 01 = esmi, 10 = dsi, 11 = dsmi (bit1 = decrypt, bit0 = mix).
- bs_i  input  2  byte select.
- rs1_i  input  32  accumulator operand.
- rs2_i  input  32  source word.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result_o  output  32  rd value.

Behaviour:
- **Reset:** the reset values below take effect on the first rising edge with reset=1. Reset mid-operation discards all in-flight requests; no partial result is ever emitted.
  - out_valid=0, result_o=0.
  - All stage valid bits are 0.
  - in_ready=1 from the first cycle after reset deasserts.
- **Accept and deliver:** a request is accepted when in_valid && in_ready; a result is delivered when out_valid && out_ready.
- **Stage 0 (combinational, at accept):**
  - Byte select: x = rs2_i[8*bs_i +: 8].
  - Apply the top layer: the forward one if op_i[1]=0, the inverse one if op_i[1]=1.
  - Apply the middle layer, giving an 18-bit value.
- **Stage 1 register (MID_REG=1):**
  - Captures: the 18-bit middle value, op, bs, rs1, and s1_valid.
  - Loads when in_valid && in_ready; when it advances with no new request, s1_valid clears.
- **Stage 2 register (output):**
  - Captures result_o and out_valid.
  - s = bottom layer (forward or inverse per op[1]) applied to the stage-1 data.
- **Mixed word m (byte3..byte0):**
  - esi/dsi: {00, 00, 00, s}.
  - esmi: {3s, s, s, 2s}.
  - dsmi: {Bs, Ds, 9s, Es}.
  - All multiplies are in GF(2^8) mod x^8+x^4+x^3+x+1.
- **Result:** result_o = rs1 ^ rol32(m, 8*bs).
- **Advance rules:**
  - Stage 2 loads when s1_valid && (!out_valid || out_ready).
  - out_valid clears when out_valid && out_ready && !s1_valid.
  - Stage 1 advances when !s1_valid || stage 2 loads.
  - in_ready = !s1_valid || (!out_valid || out_ready). This is combinational and depends on out_ready only; there is no combinational path from in_valid to in_ready.
- **Throughput:**
  - One result per cycle with no bubbles while out_ready=1.
  - Latency is accept-edge + 2 cycles to out_valid (MID_REG=0: +1).
- **Backpressure:**
  - With out_ready held at 0, the unit holds at most 2 requests (1 for MID_REG=0), then in_ready=0.
  - result_o and out_valid stay stable while out_valid && !out_ready.
- **Simultaneous events:** when stage 2 drains and stage 1 refills in the same cycle, both transfers occur and no data is lost or duplicated.
- **Value rules:** result_o is 0-masked only by reset. Outside reset it holds its last value when out_valid=0. Consumers must qualify it with out_valid.

Test Plan:
- **esi:** op=00, bs=0, rs1=0, rs2=0x00000053, out_ready=1 → out_valid exactly 2 cycles after accept, result_o=0x000000ED.
- **esmi:** op=01, bs=0, rs1=0, rs2=0 → S(0)=0x63, result_o=0xA56363C6.
  - Same with bs=2 and rs2=0x00000000 → result_o=0x63C6A563.
- **dsi/dsmi:**
  - op=10, bs=0, rs2=0 → result_o=0x00000052.
  - op=11, bs=1, rs2=0x00007C00, rs1=0xFFFFFFFF → InvS=0x01, m=0x0B0D090E, result_o=0xF2F6F1F4.
- **Backpressure:** 4 back-to-back requests with out_ready=0 → exactly 2 accepted, in_ready drops after the second and result_o stays stable; raise out_ready → results emerge in order, one per cycle, with no duplicates.
- **Streaming:** 256 consecutive esi requests with rs2 = i, out_ready=1 → in_ready stays 1 throughout, results equal the FIPS-197 S-box table, and out_valid stays high for 256 consecutive cycles.
- **Reset mid-flight:** 2 requests in flight, assert reset for 1 cycle → out_valid=0 and result_o=0 next cycle, neither pending result ever appears, and in_ready=1 once reset deasserts.

Source files
------------

// File: rtl/riscv_crypto_aes32_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_crypto_aes32_pipe
//  Purpose  : Two-stage pipelined AES32 (esi/esmi/dsi/dsmi) datapath with a
//             shared forward/inverse S-box split across the pipeline register.
//  Revision : 1.0  initial release
// ============================================================================
module riscv_crypto_aes32_pipe #(
    parameter int MID_REG = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op_i,
    input  logic [1:0]  bs_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result_o
);

    localparam logic [7:0] c_FWD_AFFINE = 8'h63;
    localparam logic [7:0] c_INV_AFFINE = 8'h05;
    localparam logic [7:0] c_GF_POLY    = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? c_GF_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc ^= sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ c_FWD_AFFINE;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ c_INV_AFFINE;
    endfunction

    function automatic logic [7:0] top_layer(input logic [7:0] x, input logic dec);
        return dec ? inv_affine(x) : x;
    endfunction

    // Inversion as t^254 = (t^17)^14 * t^16; t^17 lies in the GF(16) subfield so
    // its inverse is three squarings and two products. The final product is
    // retimed: bits [5:0] of t^16 are folded in here, bits [7:6] after the register.
    function automatic logic [17:0] mid_layer(input logic [7:0] t);
        logic [7:0] x16;
        logic [7:0] y;
        logic [7:0] y2;
        logic [7:0] y4;
        logic [7:0] y8;
        logic [7:0] yinv;
        x16  = gf_mul(t, t);
        x16  = gf_mul(x16, x16);
        x16  = gf_mul(x16, x16);
        x16  = gf_mul(x16, x16);
        y    = gf_mul(x16, t);
        y2   = gf_mul(y, y);
        y4   = gf_mul(y2, y2);
        y8   = gf_mul(y4, y4);
        yinv = gf_mul(gf_mul(y2, y4), y8);
        return {yinv, x16[7:6], gf_mul(yinv, {2'b00, x16[5:0]})};
    endfunction

    function automatic logic [7:0] bottom_layer(input logic [17:0] m, input logic dec);
        logic [7:0] inv;
        inv = m[7:0] ^ gf_mul(m[17:10], {m[9:8], 6'b000000});
        return dec ? inv : fwd_affine(inv);
    endfunction

    function automatic logic [31:0] mix_word(input logic [7:0] s, input logic [1:0] op);
        logic [7:0] s2;
        logic [7:0] s4;
        logic [7:0] s8;
        logic [31:0] m;
        s2 = xtime(s);
        s4 = xtime(s2);
        s8 = xtime(s4);
        case (op)
            2'b01:   m = {s2 ^ s, s, s, s2};
            2'b11:   m = {s8 ^ s2 ^ s, s8 ^ s4 ^ s, s8 ^ s, s8 ^ s4 ^ s2};
            default: m = {24'h000000, s};
        endcase
        return m;
    endfunction

    function automatic logic [31:0] rol_bytes(input logic [31:0] m, input logic [1:0] bs);
        logic [31:0] r;
        case (bs)
            2'd1:    r = {m[23:0], m[31:24]};
            2'd2:    r = {m[15:0], m[31:16]};
            2'd3:    r = {m[7:0],  m[31:8]};
            default: r = m;
        endcase
        return r;
    endfunction

    // ---------------- stage 0 ----------------
    logic [7:0]  w_sel_byte;
    logic [17:0] w_mid;

    assign w_sel_byte = rs2_i[{bs_i, 3'b000} +: 8];
    assign w_mid      = mid_layer(top_layer(w_sel_byte, op_i[1]));

    // ---------------- stage 1 ----------------
    logic        s1_valid;
    logic [17:0] s1_mid;
    logic [1:0]  s1_op;
    logic [1:0]  s1_bs;
    logic [31:0] s1_rs1;

    logic        out_valid_q;
    logic        out_valid_d;
    logic [31:0] result_q;
    logic [31:0] result_d;
    logic        w_s2_ready;
    logic        w_s2_load;

    assign w_s2_ready = !out_valid_q || out_ready;
    assign w_s2_load  = s1_valid && w_s2_ready;

    generate
        if (MID_REG != 0) begin : g_mid_reg
            logic        s1_valid_q;
            logic        s1_valid_d;
            logic [17:0] s1_mid_q;
            logic [17:0] s1_mid_d;
            logic [1:0]  s1_op_q;
            logic [1:0]  s1_op_d;
            logic [1:0]  s1_bs_q;
            logic [1:0]  s1_bs_d;
            logic [31:0] s1_rs1_q;
            logic [31:0] s1_rs1_d;

            assign in_ready = !s1_valid_q || w_s2_ready;

            always_comb begin
                s1_valid_d = s1_valid_q;
                s1_mid_d   = s1_mid_q;
                s1_op_d    = s1_op_q;
                s1_bs_d    = s1_bs_q;
                s1_rs1_d   = s1_rs1_q;
                if (in_ready) begin
                    s1_valid_d = in_valid;
                    if (in_valid) begin
                        s1_mid_d = w_mid;
                        s1_op_d  = op_i;
                        s1_bs_d  = bs_i;
                        s1_rs1_d = rs1_i;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    s1_valid_q <= 1'b0;
                    s1_mid_q   <= '0;
                    s1_op_q    <= '0;
                    s1_bs_q    <= '0;
                    s1_rs1_q   <= '0;
                end else begin
                    s1_valid_q <= s1_valid_d;
                    s1_mid_q   <= s1_mid_d;
                    s1_op_q    <= s1_op_d;
                    s1_bs_q    <= s1_bs_d;
                    s1_rs1_q   <= s1_rs1_d;
                end
            end

            assign s1_valid = s1_valid_q;
            assign s1_mid   = s1_mid_q;
            assign s1_op    = s1_op_q;
            assign s1_bs    = s1_bs_q;
            assign s1_rs1   = s1_rs1_q;
        end else begin : g_mid_bypass
            assign in_ready = w_s2_ready;
            assign s1_valid = in_valid;
            assign s1_mid   = w_mid;
            assign s1_op    = op_i;
            assign s1_bs    = bs_i;
            assign s1_rs1   = rs1_i;
        end
    endgenerate

    // ---------------- stage 2 ----------------
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        if (w_s2_load) begin
            out_valid_d = 1'b1;
            result_d    = s1_rs1 ^ rol_bytes(mix_word(bottom_layer(s1_mid, s1_op[1]), s1_op), s1_bs);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'h0000_0000;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result_o  = result_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_crypto_aes32_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_crypto_aes32_pipe
//  Purpose  : Directed self-checking bench for the AES32 pipelined datapath.
//  Revision : 1.0  initial release
// ============================================================================
module tb_riscv_crypto_aes32_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op_i;
    logic [1:0]  bs_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] sbox_tbl [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    riscv_crypto_aes32_pipe #(.MID_REG(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .bs_i      (bs_i),
        .rs1_i     (rs1_i),
        .rs2_i     (rs2_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_o  (result_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string tag, input logic [1:0] op, input logic [1:0] bs,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] exp);
        out_ready = 1'b1;
        op_i      = op;
        bs_i      = bs;
        rs1_i     = rs1;
        rs2_i     = rs2;
        in_valid  = 1'b1;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        step();
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".result"}, result_o, exp);
        step();
        chk({tag, ".drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int          idx;
        int          nres;
        int          first_c;
        int          last_c;
        int          nout;
        int          rdy_drops;
        int          run;
        int          maxrun;
        int          stray;
        logic        acc;
        logic [31:0] got [8];

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_i      = 2'b00;
        bs_i      = 2'b00;
        rs1_i     = 32'h0;
        rs2_i     = 32'h0;
        step();
        step();
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", result_o, 32'h0);
        reset = 1'b0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);

        // Directed single-shot vectors
        single("esi_53",     2'b00, 2'd0, 32'h0000_0000, 32'h0000_0053, 32'h0000_00ED);
        single("esmi_bs0",   2'b01, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'hA563_63C6);
        single("esmi_bs2",   2'b01, 2'd2, 32'h0000_0000, 32'h0000_0000, 32'h63C6_A563);
        single("dsi_bs0",    2'b10, 2'd0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0052);
        single("dsmi_bs1",   2'b11, 2'd1, 32'hFFFF_FFFF, 32'h0000_7C00, 32'hF2F6_F1F4);
        single("esi_bs3",    2'b00, 2'd3, 32'h1234_5678, 32'h5300_0000, 32'hFF34_5678);
        single("dsi_bs2",    2'b10, 2'd2, 32'h0000_0000, 32'h00ED_0000, 32'h0053_0000);

        // Backpressure: offer four requests with the consumer stalled
        op_i      = 2'b00;
        bs_i      = 2'd0;
        rs1_i     = 32'h0;
        out_ready = 1'b0;
        idx       = 0;
        #1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 4);
            rs2_i    = 32'(idx);
            acc      = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        chk("bp.accepted", 32'(idx), 32'd2);
        chk("bp.in_ready", 32'(in_ready), 32'd0);
        chk("bp.out_valid", 32'(out_valid), 32'd1);
        chk("bp.hold0", result_o, 32'h0000_0063);
        step();
        chk("bp.hold1", result_o, 32'h0000_0063);
        chk("bp.hold_valid", 32'(out_valid), 32'd1);

        out_ready = 1'b1;
        nres      = 0;
        first_c   = -1;
        last_c    = -1;
        #1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 4);
            rs2_i    = 32'(idx);
            if (out_valid) begin
                if (nres < 8) got[nres] = result_o;
                nres++;
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            acc = in_valid && in_ready;
            step();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        chk("bp.count", 32'(nres), 32'd4);
        chk("bp.r0", got[0], 32'h0000_0063);
        chk("bp.r1", got[1], 32'h0000_007C);
        chk("bp.r2", got[2], 32'h0000_0077);
        chk("bp.r3", got[3], 32'h0000_007B);
        chk("bp.contiguous", 32'(last_c - first_c), 32'd3);

        // Streaming: full S-box sweep back to back
        out_ready = 1'b1;
        op_i      = 2'b00;
        bs_i      = 2'd0;
        rs1_i     = 32'h0;
        nout      = 0;
        rdy_drops = 0;
        run       = 0;
        maxrun    = 0;
        #1;
        for (int c = 0; c < 262; c++) begin
            in_valid = (c < 256);
            rs2_i    = 32'(c & 255);
            if (in_valid && !in_ready) rdy_drops++;
            if (out_valid) begin
                if (nout < 256) chk("stream.sbox", result_o, {24'h0, sbox_tbl[nout]});
                nout++;
                run++;
            end else begin
                if (run > maxrun) maxrun = run;
                run = 0;
            end
            step();
        end
        if (run > maxrun) maxrun = run;
        in_valid = 1'b0;
        chk("stream.in_ready_drops", 32'(rdy_drops), 32'd0);
        chk("stream.count", 32'(nout), 32'd256);
        chk("stream.valid_run", 32'(maxrun), 32'd256);

        // Reset with two requests in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rs2_i     = 32'h0000_0010;
        step();
        rs2_i = 32'h0000_0020;
        chk("rst.second_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("rst.pending_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.result", result_o, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        stray     = 0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) stray++;
            step();
        end
        chk("rst.no_stray", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
